reaction_timer: RTL and testbench

Count-up millisecond stopwatch for the reaction-time game, complementing the level countdown timer. On `start` it waits a supplied delay, asserts the stimulus LED, then counts whole milliseconds until the player's debounced button pulse. It reports the latched reaction time, a timeout, or a false start. It sits between the game-control FSM, which supplies the delay and the start pulse, and the score/display path, which consumes `reaction_ms`.

---
 rtl/reaction_timer.sv | 138 +++++++++++++
 tb/tb_reaction_timer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/reaction_timer.sv
// Reaction-time stopwatch: waits a programmable delay, lights the stimulus LED,
// then counts whole milliseconds until the player's button pulse.
// Reports the latched reaction time, a timeout at MAX_MS, or a false start.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_IDLE     | no round in progress, all outputs low
// ST_WAIT     | pre-stimulus delay running, LED off, button = false start
// ST_ARMED    | LED on, counting ms until button or timeout
// ST_DONE     | result latched (reaction_ms / timeout), held until start
// ST_FALSE    | button came before the LED, held until start
module reaction_timer #(
    parameter int MAX_MS       = 2047,
    parameter int CLKS_PER_MS  = 50000,
    parameter int MAX_DELAY_MS = 4095,
    localparam int DW          = $clog2(MAX_DELAY_MS + 1),
    localparam int RW          = $clog2(MAX_MS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          button,
    input  logic [DW-1:0] delay_ms,
    output logic          led_on,
    output logic          busy,
    output logic          result_valid,
    output logic          timeout,
    output logic          false_start,
    output logic [RW-1:0] reaction_ms
);

    localparam int CW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_MS - 1);
    localparam logic [RW-1:0] MS_LAST  = RW'(MAX_MS - 1);
    localparam logic [RW-1:0] MS_MAX   = RW'(MAX_MS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_ARMED = 3'd2,
        ST_DONE  = 3'd3,
        ST_FALSE = 3'd4
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cyc_cnt, cyc_cnt_n;
    logic [DW-1:0] delay_cnt, delay_cnt_n;
    logic [RW-1:0] ms_cnt, ms_cnt_n;
    logic [RW-1:0] react_q, react_n;
    logic          tmo_q, tmo_n;
    logic          tick;
    logic          counting;

    // State and counter registers; reset returns to IDLE with every counter cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cyc_cnt   <= '0;
            delay_cnt <= '0;
            ms_cnt    <= '0;
            react_q   <= '0;
            tmo_q     <= 1'b0;
        end else begin
            state     <= state_n;
            cyc_cnt   <= cyc_cnt_n;
            delay_cnt <= delay_cnt_n;
            ms_cnt    <= ms_cnt_n;
            react_q   <= react_n;
            tmo_q     <= tmo_n;
        end
    end

    // Next-state, counter and result-latch logic.
    always_comb begin
        state_n     = state;
        delay_cnt_n = delay_cnt;
        ms_cnt_n    = ms_cnt;
        react_n     = react_q;
        tmo_n       = tmo_q;
        counting    = (state == ST_WAIT) || (state == ST_ARMED);
        tick        = counting && (cyc_cnt == CYC_LAST);

        case (state)
            ST_IDLE, ST_DONE, ST_FALSE: begin
                if (start) begin
                    state_n     = ST_WAIT;
                    delay_cnt_n = delay_ms;
                    react_n     = '0;
                    tmo_n       = 1'b0;
                end
            end
            ST_WAIT: begin
                // A press here always wins, even on the cycle the delay expires.
                if (button) begin
                    state_n = ST_FALSE;
                end else if (delay_cnt == '0) begin
                    state_n  = ST_ARMED;
                    ms_cnt_n = '0;
                end else if (tick) begin
                    delay_cnt_n = delay_cnt - DW'(1);
                end
            end
            ST_ARMED: begin
                // A press on a tick cycle latches the count before that tick lands.
                if (button) begin
                    state_n = ST_DONE;
                    react_n = ms_cnt;
                    tmo_n   = 1'b0;
                end else if (tick && (ms_cnt == MS_LAST)) begin
                    state_n = ST_DONE;
                    react_n = MS_MAX;
                    tmo_n   = 1'b1;
                end else if (tick) begin
                    ms_cnt_n = ms_cnt + RW'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // Cycle counter restarts on every state entry and on each ms tick.
        if (!counting || tick || (state_n != state)) begin
            cyc_cnt_n = '0;
        end else begin
            cyc_cnt_n = cyc_cnt + CW'(1);
        end
    end

    // Outputs decode straight from registered state and latches.
    assign led_on       = (state == ST_ARMED);
    assign busy         = (state == ST_WAIT) || (state == ST_ARMED);
    assign result_valid = (state == ST_DONE);
    assign false_start  = (state == ST_FALSE);
    assign timeout      = tmo_q;
    assign reaction_ms  = react_q;

endmodule

// File: tb/tb_reaction_timer.sv
// Bench for reaction_timer: a phase/elapsed-cycle model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_reaction_timer;

    localparam int C  = 4;
    localparam int M  = 20;
    localparam int MD = 15;
    localparam int DW = $clog2(MD + 1);
    localparam int RW = $clog2(M + 1);

    localparam int P_IDLE  = 0;
    localparam int P_WAIT  = 1;
    localparam int P_ARMED = 2;
    localparam int P_DONE  = 3;
    localparam int P_FALSE = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          button = 1'b0;
    logic [DW-1:0] delay_ms = '0;
    logic          led_on, busy, result_valid, timeout, false_start;
    logic [RW-1:0] reaction_ms;

    int vectors = 0;
    int miscompares = 0;

    // model: phase, cycles spent in current phase, required WAIT length, results
    int ph = P_IDLE;
    int wait_k, wait_len, arm_k;
    int r_exp = 0;
    int t_exp = 0;
    bit chk_en = 1'b0;

    reaction_timer #(.MAX_MS(M), .CLKS_PER_MS(C), .MAX_DELAY_MS(MD)) dut (
        .clk(clk), .reset(reset), .start(start), .button(button),
        .delay_ms(delay_ms), .led_on(led_on), .busy(busy),
        .result_valid(result_valid), .timeout(timeout),
        .false_start(false_start), .reaction_ms(reaction_ms)
    );

    always #5 clk = ~clk;

    // Reference model advanced on each rising edge from the sampled inputs.
    always @(posedge clk) begin
        if (reset) begin
            ph = P_IDLE; r_exp = 0; t_exp = 0; chk_en = 1'b1;
        end else begin
            case (ph)
                P_WAIT: begin
                    if (button) ph = P_FALSE;
                    else if (wait_k == wait_len - 1) begin ph = P_ARMED; arm_k = 0; end
                    else wait_k++;
                end
                P_ARMED: begin
                    if (button) begin ph = P_DONE; r_exp = arm_k / C; t_exp = 0; end
                    else if (arm_k == M * C - 1) begin ph = P_DONE; r_exp = M; t_exp = 1; end
                    else arm_k++;
                end
                default: begin
                    if (start) begin
                        ph = P_WAIT; wait_k = 0; wait_len = int'(delay_ms) * C + 1;
                        r_exp = 0; t_exp = 0;
                    end
                end
            endcase
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [RW+4:0] act, exp;
        if (chk_en) begin
            act = {led_on, busy, result_valid, timeout, false_start, reaction_ms};
            exp = {ph == P_ARMED, (ph == P_WAIT) || (ph == P_ARMED), ph == P_DONE,
                   t_exp != 0, ph == P_FALSE, RW'(r_exp)};
            vectors++;
            if (act !== exp) begin
                miscompares++;
                $display("FAIL model_cmp t=%0t dut=%b model=%b (led,busy,valid,tmo,fs,ms)",
                         $time, act, exp);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic pulse_start(input int d);
        start = 1'b1; delay_ms = DW'(d);
        step(1);
        start = 1'b0;
    endtask

    task automatic press();
        button = 1'b1;
        step(1);
        button = 1'b0;
    endtask

    task automatic wait_led(output int c);
        c = 0;
        while (!led_on && c < 200) begin step(1); c++; end
        if (!led_on) chk("led_wait_timeout", 0, 1);
    endtask

    initial begin
        int c;
        step(2);
        reset = 1'b0;
        chk("reset_outputs", {led_on, busy, result_valid, timeout, false_start, reaction_ms}, 0);

        // delay 3: 13 WAIT cycles, then press at ARMED cycle 10 -> 2 ms
        pulse_start(3);
        chk("busy_after_start", busy, 1);
        wait_led(c);
        chk("wait_len_d3", c, 13);
        step(10);
        press();
        chk("react_k10", reaction_ms, 2);
        chk("valid_k10", result_valid, 1);
        chk("tmo_k10", timeout, 0);
        chk("led_off_k10", led_on, 0);

        // false start, then recovery with delay 0 and a press on the tick cycle
        pulse_start(5);
        step(5);
        press();
        chk("fs_flag", false_start, 1);
        chk("fs_busy", busy, 0);
        chk("fs_led", led_on, 0);
        step(3);
        chk("fs_hold", false_start, 1);
        pulse_start(0);
        chk("fs_cleared", false_start, 0);
        chk("d0_wait", {busy, led_on}, 2);
        step(1);
        chk("d0_armed", led_on, 1);
        step(3);
        press();
        chk("react_k3", reaction_ms, 0);
        chk("valid_k3", result_valid, 1);

        // timeout round with ignored start pulses in WAIT and ARMED
        pulse_start(1);
        step(2);
        pulse_start(7);
        wait_led(c);
        chk("wait_ignore_start", c, 2);
        step(20);
        pulse_start(3);
        step(58);
        chk("pre_timeout_valid", result_valid, 0);
        step(1);
        chk("timeout_valid", result_valid, 1);
        chk("timeout_flag", timeout, 1);
        chk("timeout_ms", reaction_ms, M);
        press();
        step(1);
        press();
        chk("done_hold", {result_valid, timeout, reaction_ms}, (3 << RW) | M);

        // reset mid-ARMED at ms_cnt 7, start masked by reset, then clean round
        pulse_start(0);
        step(1);
        step(28);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("mid_reset_outputs", {led_on, busy, result_valid, timeout, false_start, reaction_ms}, 0);
        reset = 1'b1; start = 1'b1;
        step(1);
        reset = 1'b0; start = 1'b0;
        chk("start_with_reset", busy, 0);
        pulse_start(2);
        wait_led(c);
        chk("wait_len_after_reset", c, 9);

        // randomized traffic, checked by the model every cycle
        for (int i = 0; i < 4000; i++) begin
            start    = ($urandom_range(0, 19) == 0);
            delay_ms = DW'($urandom_range(0, 4));
            button   = ($urandom_range(0, 39) == 0);
            reset    = ($urandom_range(0, 599) == 0);
            step(1);
        end
        start = 1'b0; button = 1'b0; reset = 1'b0;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
